conv_window_packer: RTL and testbench

- Deserializer that assembles streamed operand pairs (image element, filter element) into one flattened window pair for the convolution unit.
- Sits between the feature-map/weight fetch stream and the convolution unit's parallel img/fit inputs.
- Performs the inverse of the convolution unit's element-by-element serialization.
- Valid/ready on both sides; one element accepted per cycle; back-to-back windows without bubbles.

---
 rtl/conv_window_packer_pkg.sv | 23 ++
 rtl/conv_window_packer.sv | 106 ++++++++++
 tb/tb_conv_window_packer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_packer_pkg.sv
// Shared definitions for the convolution datapath: window sizing helpers,
// packer FSM encoding and element-format defaults.
package conv_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int FLOAT_MODE_DEF = 1;   // 0 = SInt, 1 = Float

    // Elements per flattened window.
    function automatic int win_n(input int d, input int s);
        return d * s * s;
    endfunction

    // Width of a counter that must be able to hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/conv_window_packer.sv
// Deserializer: collects streamed (img, fit) element pairs into one flattened
// window pair for the convolution unit. Element k lands at [DW*k +: DW] of an
// ascending-range vector, so element 0 sits at the MSB end.
module conv_window_packer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FLOAT_MODE = FLOAT_MODE_DEF,
    parameter int D          = 1,
    parameter int S          = 5,
    localparam int N         = win_n(D, S),
    localparam int CW        = cnt_w(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_img,
    input  logic [DATA_WIDTH-1:0]     in_fit,
    input  logic                      in_last,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [0:N*DATA_WIDTH-1]   win_img,
    output logic [0:N*DATA_WIDTH-1]   win_fit,
    output logic [CW-1:0]             fill_cnt,
    output logic                      err_len
);

    // Element format only matters downstream; reject nonsense at elaboration.
    if (FLOAT_MODE > 1) begin : g_bad_mode
        $error("conv_window_packer: FLOAT_MODE must be 0 or 1");
    end

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(N);

    state_t                  r_state, w_nstate;
    logic [CW-1:0]           r_idx, w_nidx, w_widx;
    logic                    r_err, w_nerr, w_wr, w_acc;
    logic [0:N*DATA_WIDTH-1] r_img, r_fit;

    // While holding, a new pair may only enter when the consumer takes the window.
    assign in_ready  = !rst && ((r_state == FILL) || win_ready);
    assign w_acc     = in_valid && in_ready;

    assign win_valid = (r_state == HOLD);
    assign win_img   = r_img;
    assign win_fit   = r_fit;
    assign fill_cnt  = r_idx;
    assign err_len   = r_err;

    // State / index register; reset drops any partial window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_idx   <= w_nidx;
            r_err   <= w_nerr;
        end
    end

    // Next state: an accept while holding restarts the window at index 0.
    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx;
        w_nerr   = 1'b0;
        w_wr     = 1'b0;
        w_widx   = (r_state == HOLD) ? '0 : r_idx;
        if (w_acc) begin
            if (w_widx == LAST_IDX) begin
                // Window complete; a missing last is flagged but still presented.
                w_wr     = 1'b1;
                w_nidx   = FULL_CNT;
                w_nstate = HOLD;
                w_nerr   = !in_last;
            end else if (in_last) begin
                // Early last: drop the partial window and the pair itself.
                w_nidx   = '0;
                w_nstate = FILL;
                w_nerr   = 1'b1;
            end else begin
                w_wr     = 1'b1;
                w_nidx   = w_widx + 1'b1;
                w_nstate = FILL;
            end
        end else if ((r_state == HOLD) && win_ready) begin
            w_nstate = FILL;
            w_nidx   = '0;
        end
    end

    // Window registers; slots beyond the fill index keep stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_img <= '0;
            r_fit <= '0;
        end else if (w_wr) begin
            r_img[int'(w_widx)*DATA_WIDTH +: DATA_WIDTH] <= in_img;
            r_fit[int'(w_widx)*DATA_WIDTH +: DATA_WIDTH] <= in_fit;
        end
    end

endmodule

// File: tb/tb_conv_window_packer.sv
// Directed bench: a 3x3 packer (N=9) through reset, fill, backpressure,
// back-to-back windows and length errors, plus a 1x1 packer (N=1).
module tb_conv_window_packer;

    localparam int DW = 32;
    localparam int NA = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=9 instance signals
    logic             in_valid, in_ready, in_last, win_valid, win_ready, err_len;
    logic [DW-1:0]    in_img, in_fit;
    logic [0:NA*DW-1] win_img, win_fit;
    logic [3:0]       fill_cnt;

    // N=1 instance signals
    logic             b_in_valid, b_in_ready, b_in_last, b_win_valid, b_win_ready, b_err_len;
    logic [DW-1:0]    b_in_img, b_in_fit;
    logic [0:DW-1]    b_win_img, b_win_fit;
    logic [0:0]       b_fill_cnt;

    conv_window_packer #(.DATA_WIDTH(DW), .FLOAT_MODE(1), .D(1), .S(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_img(in_img), .in_fit(in_fit),
        .in_last(in_last), .win_valid(win_valid), .win_ready(win_ready),
        .win_img(win_img), .win_fit(win_fit), .fill_cnt(fill_cnt), .err_len(err_len)
    );

    conv_window_packer #(.DATA_WIDTH(DW), .FLOAT_MODE(0), .D(1), .S(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_img(b_in_img), .in_fit(b_in_fit),
        .in_last(b_in_last), .win_valid(b_win_valid), .win_ready(b_win_ready),
        .win_img(b_win_img), .win_fit(b_win_fit), .fill_cnt(b_fill_cnt), .err_len(b_err_len)
    );

    int npass = 0;
    int ntot  = 0;

    logic [0:NA*DW-1] ew, ef;   // expected window contents

    task automatic chk(input string tag, input logic [NA*DW-1:0] obs, input logic [NA*DW-1:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [DW-1:0] img, input logic [DW-1:0] fit, input logic last);
        in_valid = 1'b1; in_img = img; in_fit = fit; in_last = last;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_img = 0; in_fit = 0; in_last = 0; win_ready = 0;
        b_in_valid = 0; b_in_img = 0; b_in_fit = 0; b_in_last = 0; b_win_ready = 0;
        ew = '0; ef = '0;
        tick(); tick();

        // reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_fill_cnt", fill_cnt, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_win_img", win_img, ew);
        chk("rst_b_in_ready", b_in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // reset mid-fill after 4 elements
        for (int k = 0; k < 4; k++) push(32'hA0 + k, 32'hB0 + k, 1'b0);
        chk("partial_fill_cnt", fill_cnt, 4);
        rst = 1'b1; #1;
        chk("midrst_fill_cnt", fill_cnt, 0);
        chk("midrst_win_valid", win_valid, 0);
        chk("midrst_win_img", win_img, ew);
        chk("midrst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;

        // basic fill, consumer not ready
        for (int k = 0; k < 9; k++) begin
            push(k + 1, 32'h10 + k, k == 8);
            ew[DW*k +: DW] = k + 1;
            ef[DW*k +: DW] = 32'h10 + k;
            if (k == 7) begin
                chk("fill_k7_win_valid", win_valid, 0);
                chk("fill_k7_cnt", fill_cnt, 8);
            end
        end
        chk("fill_win_valid", win_valid, 1);
        chk("fill_cnt9", fill_cnt, 9);
        chk("fill_img_e0", win_img[0 +: 32], 1);
        chk("fill_img_e8", win_img[256 +: 32], 9);
        chk("fill_fit_e8", win_fit[256 +: 32], 32'h18);
        chk("fill_img", win_img, ew);
        chk("fill_fit", win_fit, ef);
        chk("fill_err", err_len, 0);
        chk("hold_in_ready", in_ready, 0);

        // backpressure: 5 cycles of offered input while held
        in_valid = 1'b1; in_img = 32'h55; in_fit = 32'h66; in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_win_valid", win_valid, 1);
            chk("bp_win_img", win_img, ew);
            chk("bp_fill_cnt", fill_cnt, 9);
        end
        win_ready = 1'b1; in_img = 32'h77; in_fit = 32'h88;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; win_ready = 1'b0;
        ew[0 +: DW] = 32'h77;
        ef[0 +: DW] = 32'h88;
        chk("bp_new_fill_cnt", fill_cnt, 1);
        chk("bp_new_win_valid", win_valid, 0);
        chk("bp_stale_img", win_img, ew);
        chk("bp_stale_fit", win_fit, ef);
        for (int k = 1; k < 9; k++) begin
            push(32'h70 + k, 32'h80 + k, k == 8);
            ew[DW*k +: DW] = 32'h70 + k;
            ef[DW*k +: DW] = 32'h80 + k;
        end
        chk("bp_win2_valid", win_valid, 1);
        chk("bp_win2_img", win_img, ew);
        chk("bp_win2_fit", win_fit, ef);
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;
        chk("drain_win_valid", win_valid, 0);
        chk("drain_fill_cnt", fill_cnt, 0);

        // back-to-back: 27 elements, consumer always ready
        win_ready = 1'b1;
        for (int e = 0; e < 27; e++) begin
            push(32'h100 + e, 32'h200 + e, (e % 9) == 8);
            ew[DW*(e%9) +: DW] = 32'h100 + e;
            ef[DW*(e%9) +: DW] = 32'h200 + e;
            chk("b2b_fill_cnt", fill_cnt, (e % 9) + 1);
            chk("b2b_win_valid", win_valid, (e % 9) == 8);
            chk("b2b_err", err_len, 0);
            if ((e % 9) == 8) begin
                chk("b2b_img", win_img, ew);
                chk("b2b_fit", win_fit, ef);
            end
        end
        tick();
        win_ready = 1'b0;
        chk("b2b_drain_valid", win_valid, 0);

        // early last on the 5th pair
        for (int k = 0; k < 4; k++) push(32'h400 + k, 32'h500 + k, 1'b0);
        push(32'h404, 32'h504, 1'b1);
        chk("early_err", err_len, 1);
        chk("early_fill_cnt", fill_cnt, 0);
        chk("early_win_valid", win_valid, 0);
        tick();
        chk("early_err_clear", err_len, 0);
        for (int k = 0; k < 9; k++) begin
            push(32'h300 + k, 32'h600 + k, k == 8);
            ew[DW*k +: DW] = 32'h300 + k;
            ef[DW*k +: DW] = 32'h600 + k;
        end
        chk("early_next_valid", win_valid, 1);
        chk("early_next_err", err_len, 0);
        chk("early_next_img", win_img, ew);
        chk("early_next_fit", win_fit, ef);
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;

        // missing last on the 9th pair
        for (int k = 0; k < 9; k++) begin
            push(32'h900 + k, 32'h950 + k, 1'b0);
            ew[DW*k +: DW] = 32'h900 + k;
            ef[DW*k +: DW] = 32'h950 + k;
            if (k == 7) chk("miss_k7_err", err_len, 0);
        end
        chk("miss_err", err_len, 1);
        chk("miss_win_valid", win_valid, 1);
        chk("miss_img", win_img, ew);
        chk("miss_fit", win_fit, ef);
        tick();
        chk("miss_err_clear", err_len, 0);
        chk("miss_still_valid", win_valid, 1);
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;
        chk("miss_drain", win_valid, 0);

        // N=1: every accepted pair is a window
        b_win_ready = 1'b1; b_in_valid = 1'b1; b_in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_in_img = 32'hAAA0 + k; b_in_fit = 32'hBBB0 + k;
            tick();
            chk("n1_win_valid", b_win_valid, 1);
            chk("n1_win_img", b_win_img, 32'hAAA0 + k);
            chk("n1_win_fit", b_win_fit, 32'hBBB0 + k);
            chk("n1_fill_cnt", b_fill_cnt, 1);
            chk("n1_err", b_err_len, 0);
        end
        b_in_last = 1'b0; b_in_img = 32'hCCC0;
        tick();
        chk("n1_miss_err", b_err_len, 1);
        chk("n1_miss_img", b_win_img, 32'hCCC0);
        b_in_valid = 1'b0;
        tick();
        chk("n1_drain", b_win_valid, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
